// File: rtl/prog_loader_pkg.sv
// ============================================================================
// Module   : prog_loader_pkg
// Purpose  : Shared widths, bytes-per-instruction helper and loader states.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package prog_loader_pkg;

    localparam int N     = 8;
    localparam int PSIZE = 4;
    localparam int ISIZE = N + 9;

    function automatic int bytes_per_instr(input int isize);
        return (isize + 7) / 8;
    endfunction

    localparam int BPI = bytes_per_instr(ISIZE);
    localparam int PAD = BPI * 8 - ISIZE;

    typedef enum logic [2:0] {
        ST_COUNT = 3'd0,
        ST_DATA  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/prog_loader_if.sv
// ============================================================================
// Module   : prog_loader_if
// Purpose  : Byte-stream input and program-memory write port of the loader.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface prog_loader_if;
    import prog_loader_pkg::*;

    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             wr_en;
    logic [PSIZE-1:0] wr_addr;
    logic [ISIZE-1:0] wr_data;

    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

`default_nettype wire

// File: rtl/prog_loader_byte_packer.sv
// ============================================================================
// Module   : byte_packer
// Purpose  : Assembles BPI MSB-first bytes into one instruction word.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module byte_packer
    import prog_loader_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             clear,
    input  wire logic             byte_en,
    input  wire logic [7:0]       byte_in,
    output logic      [ISIZE-1:0] word,
    output logic                  word_valid,
    output logic                  pad_err
);
    localparam int c_iw = (BPI > 1) ? $clog2(BPI) : 1;

    logic [c_iw-1:0]  r_idx;
    logic [ISIZE-9:0] r_sr;
    logic             w_first;
    logic             w_last;

    assign w_first    = (r_idx == '0);
    assign w_last     = (r_idx == c_iw'(BPI - 1));
    // Word including the byte on the input this cycle, so a write needs no extra stage.
    assign word       = {r_sr, byte_in};
    assign word_valid = byte_en && w_last;

    generate
        if (PAD > 0) begin : g_pad
            assign pad_err = byte_en && w_first && (byte_in[7 -: PAD] != '0);
        end else begin : g_no_pad
            assign pad_err = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_idx <= '0;
            r_sr  <= '0;
        end else if (byte_en) begin
            r_sr  <= word[ISIZE-9:0];
            r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
    end
endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module   : prog_loader
// Purpose  : Boot-time program-memory writer with XOR checksum and CPU hold.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prog_loader
    import prog_loader_pkg::*;
(
    input  wire logic    clk,
    input  wire logic    reset,
    prog_loader_if.slave bus,
    input  wire logic    start,
    output logic         cpu_hold,
    output logic         done,
    output logic         error
);
    localparam logic [8:0] c_max_count = 9'(1 << PSIZE);

    loader_state_t    r_state;
    loader_state_t    w_next;
    logic [PSIZE:0]   r_remaining;
    logic [PSIZE-1:0] r_addr;
    logic [7:0]       r_csum;
    logic             r_wr_en;
    logic [PSIZE-1:0] r_wr_addr;
    logic [ISIZE-1:0] r_wr_data;

    logic [8:0]       w_count9;
    logic             w_count_ok;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_clear;
    logic             w_byte_en;
    logic             w_word_valid;
    logic             w_pad_err;
    logic [ISIZE-1:0] w_word;

    assign w_count9   = {1'b0, bus.in_data};
    assign w_count_ok = (w_count9 <= c_max_count);
    assign w_in_ready = (r_state == ST_COUNT) || (r_state == ST_DATA) || (r_state == ST_CHECK);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_clear    = (r_state == ST_COUNT) && w_accept;
    assign w_byte_en  = (r_state == ST_DATA) && w_accept;

    assign bus.in_ready = w_in_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_clear),
        .byte_en    (w_byte_en),
        .byte_in    (bus.in_data),
        .word       (w_word),
        .word_valid (w_word_valid),
        .pad_err    (w_pad_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_COUNT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        done     = 1'b0;
        error    = 1'b0;
        cpu_hold = 1'b1;
        unique case (r_state)
            ST_COUNT: if (w_accept) w_next = w_count_ok ? ST_DATA : ST_ERROR;
            ST_DATA: begin
                if (w_pad_err) begin
                    w_next = ST_ERROR;
                end else if (w_word_valid && (r_remaining == (PSIZE+1)'(1))) begin
                    w_next = ST_CHECK;
                end
            end
            ST_CHECK: if (w_accept) w_next = (bus.in_data == r_csum) ? ST_DONE : ST_ERROR;
            ST_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) w_next = ST_COUNT;
            end
            ST_ERROR: begin
                error = 1'b1;
                if (start) w_next = ST_COUNT;
            end
            default: w_next = ST_ERROR;
        endcase
    end

    // A count of zero means a full memory image of 2^PSIZE words.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_remaining <= '0;
            r_addr      <= '0;
            r_csum      <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_clear) begin
                r_remaining <= (bus.in_data == 8'd0) ? c_max_count[PSIZE:0] : w_count9[PSIZE:0];
                r_addr      <= '0;
                r_csum      <= '0;
            end else if (w_byte_en) begin
                r_csum <= r_csum ^ bus.in_data;
                if (w_word_valid) begin
                    r_wr_en     <= 1'b1;
                    r_wr_addr   <= r_addr;
                    r_wr_data   <= w_word;
                    r_addr      <= r_addr + 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                end
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module   : tb_prog_loader
// Purpose  : Stream-level reference model and per-cycle compare for prog_loader.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;
    import prog_loader_pkg::*;

    typedef enum {M_BUSY, M_DONE, M_ERR} mstat_t;
    typedef logic [PSIZE+ISIZE-1:0] wentry_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic cpu_hold, done, error;

    prog_loader_if bus ();

    prog_loader dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .start    (start),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: interpret the accepted byte stream by position.
    mstat_t           m_stat = M_BUSY;
    logic [7:0]       m_q[$];
    logic             m_wr = 1'b0;
    logic [PSIZE-1:0] m_addr = '0;
    logic [ISIZE-1:0] m_data = '0;
    bit               chk_en = 1'b0;
    wentry_t          wlog[$];

    always @(posedge clk) begin
        int c, nw, k;
        logic [7:0]  x;
        logic [63:0] acc;
        chk_en = 1'b1;
        m_wr   = 1'b0;
        if (reset) begin
            m_q.delete();
            m_stat = M_BUSY;
        end else if (m_stat != M_BUSY) begin
            if (start) begin
                m_q.delete();
                m_stat = M_BUSY;
            end
        end else if (bus.in_valid) begin
            m_q.push_back(bus.in_data);
            c  = int'(m_q[0]);
            nw = (c == 0) ? (1 << PSIZE) : c;
            if (c > (1 << PSIZE)) begin
                m_stat = M_ERR;
            end else if (m_q.size() > 1) begin
                k = m_q.size() - 2;
                if (k < nw * BPI) begin
                    if ((k % BPI == 0) && ((int'(m_q[k+1]) >> (8 - PAD)) != 0)) begin
                        m_stat = M_ERR;
                    end else if (k % BPI == BPI - 1) begin
                        acc = '0;
                        for (int j = k - BPI + 2; j <= k + 1; j++) acc = (acc << 8) | 64'(m_q[j]);
                        m_wr   = 1'b1;
                        m_addr = PSIZE'((k / BPI) % (1 << PSIZE));
                        m_data = ISIZE'(acc);
                    end
                end else begin
                    x = '0;
                    for (int j = 1; j <= nw * BPI; j++) x = x ^ m_q[j];
                    m_stat = (x == bus.in_data) ? M_DONE : M_ERR;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(bus.in_ready), 32'(m_stat == M_BUSY));
            chk("done",     32'(done),         32'(m_stat == M_DONE));
            chk("error",    32'(error),        32'(m_stat == M_ERR));
            chk("cpu_hold", 32'(cpu_hold),     32'(m_stat != M_DONE));
            chk("wr_en",    32'(bus.wr_en),    32'(m_wr));
            if (m_wr) begin
                chk("wr_addr", 32'(bus.wr_addr), 32'(m_addr));
                chk("wr_data", 32'(bus.wr_data), 32'(m_data));
            end
            if (bus.wr_en) wlog.push_back({bus.wr_addr, bus.wr_data});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] s[$], input int gap_pct);
        int wait_cnt;
        foreach (s[i]) begin
            if (m_stat != M_BUSY) break;
            while ($urandom_range(99) < gap_pct) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = s[i];
            wait_cnt     = 0;
            @(negedge clk);
            while (!bus.in_ready && wait_cnt < 50) begin
                @(negedge clk);
                wait_cnt++;
            end
            if (!bus.in_ready) begin
                chk("accept_timeout", 32'd0, 32'd1);
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] s[$], input int lo, input int hi);
        logic [7:0] x = '0;
        for (int j = lo; j <= hi; j++) x = x ^ s[j];
        return x;
    endfunction

    logic [7:0] s[$];
    logic [7:0] part[$];
    wentry_t    saved[$];

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        idle(3);
        chk("rst_wr_addr",  32'(bus.wr_addr),  32'd0);
        chk("rst_wr_data",  32'(bus.wr_data),  32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_cpu_hold", 32'(cpu_hold),     32'd1);
        reset = 1'b0;

        // Good two-word load
        s = '{8'h02, 8'h00, 8'h12, 8'h34, 8'h01, 8'hAB, 8'hCD, 8'h41};
        wlog.delete();
        send(s, 0);
        idle(2);
        chk("good_nwr", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            chk("good_w0", 32'(wlog[0]), 32'({4'd0, 17'h01234}));
            chk("good_w1", 32'(wlog[1]), 32'({4'd1, 17'h1ABCD}));
        end
        chk("good_done", 32'(done),     32'd1);
        chk("good_hold", 32'(cpu_hold), 32'd0);

        // Bad checksum, with gaps
        pulse_start();
        chk("start_done", 32'(done),     32'd0);
        chk("start_hold", 32'(cpu_hold), 32'd1);
        s[7] = 8'h40;
        wlog.delete();
        send(s, 30);
        idle(2);
        chk("badcs_nwr",   32'(wlog.size()),  32'd2);
        chk("badcs_error", 32'(error),        32'd1);
        chk("badcs_ready", 32'(bus.in_ready), 32'd0);
        chk("badcs_hold",  32'(cpu_hold),     32'd1);

        // Pad bit set, then oversize count
        pulse_start();
        wlog.delete();
        s = '{8'h01, 8'h02};
        send(s, 0);
        chk("pad_error", 32'(error), 32'd1);
        idle(2);
        chk("pad_nwr", 32'(wlog.size()), 32'd0);
        pulse_start();
        s = '{8'h11};
        send(s, 0);
        chk("cnt_error", 32'(error), 32'd1);

        // Full 2^PSIZE image, full rate then with gaps
        s = '{8'h00};
        for (int w = 0; w < (1 << PSIZE); w++) begin
            s.push_back(8'($urandom_range(0, 1)));
            for (int b = 1; b < BPI; b++) s.push_back(8'($urandom_range(0, 255)));
        end
        s.push_back(xsum(s, 1, s.size() - 1));
        pulse_start();
        wlog.delete();
        send(s, 0);
        idle(2);
        chk("full_nwr",  32'(wlog.size()), 32'(1 << PSIZE));
        chk("full_done", 32'(done), 32'd1);
        foreach (wlog[i]) chk("full_addr", 32'(wlog[i][PSIZE+ISIZE-1:ISIZE]), 32'(i));
        saved = wlog;
        pulse_start();
        wlog.delete();
        send(s, 40);
        idle(2);
        chk("gap_nwr", 32'(wlog.size()), 32'(saved.size()));
        if (wlog.size() == saved.size())
            foreach (wlog[i]) chk("gap_same", 32'(wlog[i]), 32'(saved[i]));

        // Reset mid-load, then replay
        s = '{8'h02, 8'h00, 8'h12, 8'h34, 8'h01, 8'hAB, 8'hCD, 8'h41};
        part = s[0:3];
        pulse_start();
        send(part, 0);
        do_reset();
        wlog.delete();
        idle(3);
        chk("mid_nwr",   32'(wlog.size()),  32'd0);
        chk("mid_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_hold",  32'(cpu_hold),     32'd1);
        send(s, 20);
        idle(2);
        chk("replay_nwr",  32'(wlog.size()), 32'd2);
        chk("replay_done", 32'(done),        32'd1);

        // Re-arm from DONE with a one-word program
        pulse_start();
        chk("rearm_done", 32'(done),     32'd0);
        chk("rearm_hold", 32'(cpu_hold), 32'd1);
        s = '{8'h01, 8'h00, 8'h00, 8'h07, 8'h07};
        wlog.delete();
        send(s, 0);
        idle(2);
        chk("rearm_nwr", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) chk("rearm_w0", 32'(wlog[0]), 32'({4'd0, 17'h00007}));
        chk("rearm_ok", 32'(done), 32'd1);

        // Randomised loads with occasional corruption
        for (int it = 0; it < 10; it++) begin
            int c;
            c = ($urandom_range(9) == 0) ? int'($urandom_range(17, 255)) :
                ($urandom_range(9) == 0) ? 0 : int'($urandom_range(1, 6));
            s = '{8'(c)};
            for (int w = 0; w < ((c == 0) ? (1 << PSIZE) : (c > 16 ? 0 : c)); w++) begin
                s.push_back(($urandom_range(14) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1)));
                for (int b = 1; b < BPI; b++) s.push_back(8'($urandom_range(0, 255)));
            end
            s.push_back(($urandom_range(4) == 0) ? 8'($urandom_range(0, 255)) : xsum(s, 1, s.size() - 1));
            pulse_start();
            send(s, int'($urandom_range(0, 50)));
            idle(3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end
endmodule

`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Boot-time writer for the picoMIPS program memory. Accepts a byte stream over a valid/ready handshake, assembles Isize-bit instruction words, writes them to consecutive program-memory addresses from 0, and verifies an XOR checksum. While loading, and after any error, it holds the CPU in reset; on a successful load it releases the CPU. The CPU's program counter is the reader of the memory, and this block is the writer.

## Interface
- `n`, 8, datapath width.
- `Psize`, 4, program address width; legal range 1..8.
- `Isize`, n+9, instruction width: opcode(3) + Raddr1(3) + Raddr2(3) + imm(n).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a byte.
- `start`  in  1  single-cycle pulse that re-arms loading from DONE or ERROR.
- `wr_en`  out  1  program-memory write strobe, one cycle per write.
- `wr_addr`  out  Psize  write address.
- `wr_data`  out  Isize  write data.
- `cpu_hold`  out  1  drive to the CPU reset; high holds the CPU.
- `done`  out  1  load completed and checksum matched.
- `error`  out  1  load aborted.

## Operation
- A byte is accepted on any cycle where `in_valid && in_ready`. Bytes are never dropped or duplicated.
- Stream format:
  - Count byte C: the number of instructions. C=0 means 2^Psize.
  - C × BPI instruction bytes, with BPI=(Isize+7)/8, MSB-first.
  - One checksum byte: the XOR of all instruction bytes. The count byte is excluded.
- States are COUNT, DATA, CHECK, DONE and ERROR.
- **COUNT**
  - Accept C. If C > 2^Psize, go to ERROR.
  - Otherwise load the remaining-instruction counter and clear the address, byte index and checksum. Go to DATA.
- **DATA**
  - Shift each accepted byte into the assembly register and XOR it into the checksum.
  - The top BPI×8−Isize bits of the word must be 0. With defaults this is bits 7:1 of the first byte. A nonzero bit means: go to ERROR, with no write for that word.
  - On the BPI-th byte, register `wr_data` = the low Isize bits and `wr_addr` = the current address, and pulse `wr_en` on the next cycle.
  - Then increment the address, which wraps mod 2^Psize, and decrement the counter. When the counter reaches 0, go to CHECK.
- **CHECK**
  - Accept the checksum byte. On a match go to DONE; otherwise go to ERROR.
- **DONE**: `done`=1, `cpu_hold`=0, `in_ready`=0.
- **ERROR**: `error`=1, `cpu_hold`=1, `in_ready`=0.
- `start` in DONE or ERROR:
  - go to COUNT;
  - clear `done` and `error`;
  - set `cpu_hold`=1.
- `start` in any other state is ignored.
- `in_ready` = 1 exactly in COUNT, DATA and CHECK.

## Timing
- Reset values: state COUNT, `in_ready`=1 (from the first cycle after reset), `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cpu_hold`=1, `done`=0, `error`=0.
- Write latency: `wr_en` is high for exactly one cycle, the cycle after the last byte of a word is accepted. `wr_addr`/`wr_data` are stable in that cycle.
- Back-to-back bytes at full rate are required. The write pipeline never deasserts `in_ready`.
- Gaps in `in_valid` insert idle cycles without any state change.
- DONE/ERROR are entered the cycle after the deciding byte is accepted. `cpu_hold` falls in that same cycle on DONE.
- `start` while `reset` is high is ignored; reset wins.
- Reset mid-load returns to COUNT immediately. Memory already written is not erased. Any pending `wr_en` is suppressed.
- Address wrap: with C=0, writes cover addresses 0..2^Psize−1 exactly once.

## Structure
- Package `prog_loader_pkg`:
  - state enum typedef `loader_state_t`;
  - localparam function for BPI;
  - the widths `Psize`/`Isize` derivation shared with picoMIPS.
- Sub-module `byte_packer`:
  - BPI-deep shift register and byte index, with `word_valid` and pad-bit-error outputs;
  - the FSM stays in `prog_loader`.
- The program memory becomes a write-port RAM; connecting it is a top-level change.

## Test plan
- Good load: count 0x02, bytes 00 12 34 01 AB CD, checksum 0x41 -> writes addr0=0x01234 and addr1=0x1ABCD, `done`=1, `cpu_hold`=0.
- Same stream with checksum 0x40 -> both writes occur, then `error`=1, `cpu_hold` stays 1, `in_ready`=0.
- Count 0x01, first byte 0x02 (pad bit set) -> `error`=1 the next cycle, no `wr_en`; count 0x11 -> ERROR immediately.
- Count 0x00 with 16 words -> 16 writes at addresses 0..15, no wrap overrun, `done`=1; random `in_valid` gaps give identical writes.
- Reset asserted after 4 bytes of a good stream -> no further `wr_en`, COUNT state, `in_ready`=1, `cpu_hold`=1; replaying the full stream succeeds.
- `start` pulse in DONE -> `done`=0, `cpu_hold`=1, a second stream of count 0x01, bytes 00 00 07, checksum 0x07 writes addr0=0x00007.
